bit_sample_engine: RTL and testbench

BIT_SAMPLE_ENGINE -- requirements
Module: bit_sample_engine

---
 rtl/bit_sample_engine.sv | 201 ++++++++++++++++++++
 tb/tb_bit_sample_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_sample_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bit_sample_engine
//  Purpose  : Oversampling asynchronous serial receiver. The line is
//             synchronised, each bit is resolved by a 2-of-3 majority vote
//             around mid-bit, and a completed frame is reported with a
//             one-clock dataValid pulse. Error flags are held until the next
//             frame completes.
//  Ports    : clk          - clock, all state updates on the rising edge
//             rst_n        - synchronous active-low reset
//             sampleTick   - oversample strobe, one clk wide
//             serialIn     - asynchronous serial line, idles high
//             dataOut      - last received word (LSB first on the line)
//             dataValid    - one-clk pulse marking a completed frame
//             parityError  - parity mismatch of the last frame
//             framingError - stop bit sampled low in the last frame
//             busy         - receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module bit_sample_engine #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sampleTick,
    input  logic                 serialIn,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 parityError,
    output logic                 framingError,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int MID   = OVERSAMPLE / 2;

    localparam logic [CNT_W-1:0] C_CNT_MIDM1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] C_CNT_MID   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] C_CNT_MIDP1 = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] C_BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 sync1_q, lineS_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitIdx_q, bitIdx_d;
    logic [1:0]           samp_q, samp_d;     // [1] = sample at MID-1, [0] = at MID
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parBit_q, parBit_d;
    logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
    logic                 dataValid_q, dataValid_d;
    logic                 parErr_q, parErr_d;
    logic                 frmErr_q, frmErr_d;

    logic                 w_maj;
    logic                 w_xor;
    logic                 w_par_err;
    logic [CNT_W-1:0]     w_cnt_next;

    // The third vote is the live synchronised line at cnt = MID+1.
    assign w_maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & lineS_q) | (samp_q[0] & lineS_q);
    assign w_cnt_next = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    assign w_xor = ^{shift_q, parBit_q};

    always_comb begin
        w_par_err = 1'b0;
        if (PARITY_MODE == 1) begin
            w_par_err = w_xor;
        end else if (PARITY_MODE == 2) begin
            w_par_err = ~w_xor;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitIdx_d    = bitIdx_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        parBit_d    = parBit_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
        parErr_d    = parErr_q;
        frmErr_d    = frmErr_q;

        if (sampleTick) begin
            case (state_q)
                S_IDLE: begin
                    if (!lineS_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_BREAK: begin
                    if (lineS_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_START, S_DATA, S_PARITY, S_STOP: begin
                    cnt_d = w_cnt_next;
                    if (cnt_q == C_CNT_MIDM1) samp_d[1] = lineS_q;
                    if (cnt_q == C_CNT_MID)   samp_d[0] = lineS_q;

                    case (state_q)
                        S_START: begin
                            if (cnt_q == C_CNT_MIDP1 && w_maj) begin
                                // Start bit did not survive the vote: treat as a glitch.
                                state_d = S_IDLE;
                                cnt_d   = '0;
                            end else if (cnt_q == C_CNT_LAST) begin
                                state_d  = S_DATA;
                                bitIdx_d = '0;
                            end
                        end
                        S_DATA: begin
                            if (cnt_q == C_CNT_MIDP1) begin
                                shift_d = {w_maj, shift_q[DATA_BITS-1:1]};
                            end
                            if (cnt_q == C_CNT_LAST) begin
                                if (bitIdx_q == C_BIT_LAST) begin
                                    bitIdx_d = '0;
                                    state_d  = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                                end else begin
                                    bitIdx_d = bitIdx_q + BIT_W'(1);
                                end
                            end
                        end
                        S_PARITY: begin
                            if (cnt_q == C_CNT_MIDP1) parBit_d = w_maj;
                            if (cnt_q == C_CNT_LAST)  state_d  = S_STOP;
                        end
                        default: begin // S_STOP
                            if (cnt_q == C_CNT_MIDP1) begin
                                // Report at mid-stop so the next start edge is never missed.
                                dataOut_d   = shift_q;
                                parErr_d    = w_par_err;
                                frmErr_d    = ~w_maj;
                                dataValid_d = 1'b1;
                                cnt_d       = '0;
                                state_d     = (!w_maj && shift_q == '0) ? S_BREAK : S_IDLE;
                            end
                        end
                    endcase
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            lineS_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            parBit_q    <= 1'b0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            frmErr_q    <= 1'b0;
        end else begin
            sync1_q     <= serialIn;
            lineS_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            parBit_q    <= parBit_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            frmErr_q    <= frmErr_d;
        end
    end

    assign dataOut      = dataOut_q;
    assign dataValid    = dataValid_q;
    assign parityError  = parErr_q;
    assign framingError = frmErr_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bit_sample_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_sample_engine
//  Purpose  : Directed self-checking bench for bit_sample_engine. Instance 0
//             runs without parity, instance 1 runs with even parity; each has
//             its own serial line while clock, reset and sampleTick are shared.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_sample_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sampleTick = 1'b0;
    logic       ser0 = 1'b1;
    logic       ser1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int dv_cnt0 = 0;
    int dv_cnt1 = 0;
    int tick_div = 1;
    int base0, base1;

    bit_sample_engine #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sampleTick(sampleTick), .serialIn(ser0),
        .dataOut(dout0), .dataValid(dv0), .parityError(pe0),
        .framingError(fe0), .busy(busy0)
    );

    bit_sample_engine #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sampleTick(sampleTick), .serialIn(ser1),
        .dataOut(dout1), .dataValid(dv1), .parityError(pe1),
        .framingError(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Count clocks with dataValid high; a pulse wider than one clk shows up as extra counts.
    always @(negedge clk) begin
        if (dv0) dv_cnt0++;
        if (dv1) dv_cnt1++;
    end

    task automatic do_tick();
        @(negedge clk);
        sampleTick = 1'b1;
        for (int k = 1; k < tick_div; k++) begin
            @(negedge clk);
            sampleTick = 1'b0;
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 1) ser1 = v;
        else          ser0 = v;
    endtask

    task automatic send_bit(input int sel, input logic v, input int n);
        set_line(sel, v);
        repeat (n) do_tick();
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        send_bit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], 16);
        if (par_en) send_bit(sel, par, 16);
        send_bit(sel, stop, 16);
        send_bit(sel, 1'b1, 24);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout0: got %h expected 00", dout0); end
        checks++; if ({dv0, pe0, fe0, busy0} !== 4'b0000) begin errors++; $display("FAIL reset_flags0: got %b expected 0000", {dv0, pe0, fe0, busy0}); end
        checks++; if ({dout1, dv1, pe1, fe1, busy1} !== 12'h000) begin errors++; $display("FAIL reset_dut1: got %h expected 000", {dout1, dv1, pe1, fe1, busy1}); end
        rst_n = 1'b1;
        repeat (20) do_tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy0: got %b expected 0", busy0); end
    endtask

    task automatic test_8n1();
        base0 = dv_cnt0;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        checks++; if (dv_cnt0 - base0 !== 1) begin errors++; $display("FAIL 8n1_dv_pulses: got %0d expected 1", dv_cnt0 - base0); end
        checks++; if (dout0 !== 8'h55) begin errors++; $display("FAIL 8n1_data: got %h expected 55", dout0); end
        checks++; if ({pe0, fe0} !== 2'b00) begin errors++; $display("FAIL 8n1_errors: got %b expected 00", {pe0, fe0}); end
        checks++; if ({busy0, dv0} !== 2'b00) begin errors++; $display("FAIL 8n1_busy_dv: got %b expected 00", {busy0, dv0}); end
    endtask

    task automatic test_start_glitch();
        base0 = dv_cnt0;
        send_bit(0, 1'b0, 4);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", busy0); end
        send_bit(0, 1'b1, 16);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", busy0); end
        checks++; if (dv_cnt0 - base0 !== 0) begin errors++; $display("FAIL glitch_no_dv: got %0d expected 0", dv_cnt0 - base0); end
        checks++; if (dout0 !== 8'h55) begin errors++; $display("FAIL glitch_data_kept: got %h expected 55", dout0); end
    endtask

    task automatic test_parity();
        base1 = dv_cnt1;
        send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
        checks++; if (dv_cnt1 - base1 !== 1) begin errors++; $display("FAIL par_bad_dv: got %0d expected 1", dv_cnt1 - base1); end
        checks++; if (dout1 !== 8'hA3) begin errors++; $display("FAIL par_bad_data: got %h expected a3", dout1); end
        checks++; if ({pe1, fe1} !== 2'b10) begin errors++; $display("FAIL par_bad_flags: got %b expected 10", {pe1, fe1}); end
        send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1);
        checks++; if (dv_cnt1 - base1 !== 2) begin errors++; $display("FAIL par_good_dv: got %0d expected 2", dv_cnt1 - base1); end
        checks++; if (dout1 !== 8'hA3) begin errors++; $display("FAIL par_good_data: got %h expected a3", dout1); end
        checks++; if ({pe1, fe1} !== 2'b00) begin errors++; $display("FAIL par_good_flags: got %b expected 00", {pe1, fe1}); end
    endtask

    task automatic test_break();
        base0 = dv_cnt0;
        send_bit(0, 1'b0, 192);
        checks++; if (dv_cnt0 - base0 !== 1) begin errors++; $display("FAIL brk_dv: got %0d expected 1", dv_cnt0 - base0); end
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL brk_data: got %h expected 00", dout0); end
        checks++; if ({pe0, fe0} !== 2'b01) begin errors++; $display("FAIL brk_flags: got %b expected 01", {pe0, fe0}); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL brk_busy_held: got %b expected 1", busy0); end
        send_bit(0, 1'b1, 8);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL brk_release: got %b expected 0", busy0); end
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        checks++; if (dv_cnt0 - base0 !== 2) begin errors++; $display("FAIL brk_next_dv: got %0d expected 2", dv_cnt0 - base0); end
        checks++; if (dout0 !== 8'h3C) begin errors++; $display("FAIL brk_next_data: got %h expected 3c", dout0); end
        checks++; if ({pe0, fe0} !== 2'b00) begin errors++; $display("FAIL brk_next_flags: got %b expected 00", {pe0, fe0}); end
    endtask

    task automatic test_noise_slow_tick();
        tick_div = 3;
        base0 = dv_cnt0;
        send_bit(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0, 16);
        send_bit(0, 1'b0, 8);
        send_bit(0, 1'b1, 1);
        send_bit(0, 1'b0, 7);
        for (int i = 4; i < 8; i++) send_bit(0, 1'b0, 16);
        send_bit(0, 1'b1, 16);
        send_bit(0, 1'b1, 24);
        checks++; if (dv_cnt0 - base0 !== 1) begin errors++; $display("FAIL noise_dv: got %0d expected 1", dv_cnt0 - base0); end
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL noise_data: got %h expected 00", dout0); end
        checks++; if ({pe0, fe0, busy0} !== 3'b000) begin errors++; $display("FAIL noise_flags: got %b expected 000", {pe0, fe0, busy0}); end
        tick_div = 1;
    endtask

    task automatic test_reset_midframe();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        base0 = dv_cnt0;
        send_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0, 16);
        send_bit(0, 1'b1, 8);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", dout0); end
        checks++; if ({dv0, pe0, fe0, busy0} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", {dv0, pe0, fe0, busy0}); end
        checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL midrst_dut1: got %h expected 00", dout1); end
        send_bit(0, 1'b1, 40);
        checks++; if (dv_cnt0 - base0 !== 0) begin errors++; $display("FAIL midrst_no_dv: got %0d expected 0", dv_cnt0 - base0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 0", busy0); end
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        checks++; if (dv_cnt0 - base0 !== 1) begin errors++; $display("FAIL midrst_next_dv: got %0d expected 1", dv_cnt0 - base0); end
        checks++; if (dout0 !== 8'hC3) begin errors++; $display("FAIL midrst_next_data: got %h expected c3", dout0); end
        checks++; if ({pe0, fe0} !== 2'b00) begin errors++; $display("FAIL midrst_next_flags: got %b expected 00", {pe0, fe0}); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_start_glitch();
        test_parity();
        test_break();
        test_noise_slow_tick();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
